clk_cfg_sequencer: RTL
======================

Name: clk_cfg_sequencer

Overview:
- Sequences sample-rate changes for the audio clock tree: MCLK oscillator select, divider reset, and the two divide exponents fed to the power-of-2 clock divider.
- Gives a glitch-free change: mute DAC, hold divider in reset, switch oscillator and exponents, wait for the oscillator to settle, release, unmute.
- Sits between the FX2LP command decoder (req/ack) and the clock divider, MCLK mux and DAC mute pin.

Parameters:
- MUTE_CYCLES, 256, clk cycles spent in each of MUTE and UNMUTE (>=1).
- SETTLE_CYCLES, 1024, clk cycles divider is held in reset after oscillator switch (>=1).
- CNT_W, 16, wait-counter width; must satisfy 2^CNT_W >= max(MUTE_CYCLES, SETTLE_CYCLES).

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  1  rate-change request, 4-phase level.
- rate_code  in  3  0=44.1k 1=48k 2=88.2k 3=96k 4=176.4k 5=192k; 6,7 unsupported.
- ack  out  1  request completed; held until req low.
- err  out  1  last request unsupported; valid while ack=1.
- busy  out  1  sequence in progress (any state other than IDLE/ACK).
- mute  out  1  DAC soft-mute.
- osc_sel  out  1  0 = 22.5792 MHz (44.1k family), 1 = 24.576 MHz (48k family).
- div_rst_n  out  1  active-low reset to clock divider.
- div1  out  3  BCLK exponent (64fs).
- div2  out  3  16fs tick exponent.

Behaviour:
- Clock and reset: one clock domain; reset is asynchronous and active-low on rst_n. All outputs are registered.
- Reset values: state BOOT, mute=1, div_rst_n=0, busy=1, ack=0, err=0, osc_sel=0, div1=3, div2=5, cur_code=0.
- Rate table (MCLK = 512fs base):
  - codes 0/1: div1=3, div2=5
  - codes 2/3: div1=2, div2=4
  - codes 4/5: div1=1, div2=3
  - osc_sel = rate_code[0]
- States:
  - BOOT: 1 cycle, then SETTLE with code 0 config.
  - IDLE: if req=1, latch rate_code.
    - Unsupported code: go to ACK with err=1, no output change.
    - Code equals cur_code: go to ACK with err=0, no sequence.
    - Otherwise: go to MUTE.
  - MUTE: mute=1; lasts exactly MUTE_CYCLES, then HOLD.
  - HOLD: div_rst_n=0 for 1 cycle. osc_sel/div1/div2/cur_code update on the HOLD->SETTLE edge.
  - SETTLE: div_rst_n=0; lasts SETTLE_CYCLES, then UNMUTE with div_rst_n=1.
  - UNMUTE: mute=1, divider running; lasts MUTE_CYCLES, then mute=0.
    - Go to ACK if entered from a request.
    - Go to IDLE if entered from BOOT (no ack).
  - ACK: ack=1; return to IDLE on the first cycle req=0. ack and err drop together.
- Waits use a down-counter loaded with N-1; the state exits when the count is 0.
- Latency: req sampled high in IDLE to ack=1 is 1+MUTE_CYCLES+1+SETTLE_CYCLES+MUTE_CYCLES cycles. Same-code or error requests take 1 cycle.
- Boundary rules:
  - rate_code changes after latching are ignored.
  - req dropping mid-sequence is ignored; the sequence completes, and ack is high for exactly 1 cycle if req is already low in ACK.
  - req held high through ACK->IDLE cannot retrigger, because ACK exits only on req=0.
  - Reset asserted mid-sequence: immediate return to reset values, then the BOOT sequence repeats.
  - busy=0 only in IDLE and ACK.
  - div_rst_n and config never change while mute=0.

Decomposition:
- Package clk_cfg_pkg holds:
  - state enum (BOOT, IDLE, MUTE, HOLD, SETTLE, UNMUTE, ACK)
  - rate code constants
  - function rate_lookup(code) returning {valid, osc_sel, div1, div2}
- One sub-module, clk_cfg_timer: loadable CNT_W down-counter with load, value and done (count==0) outputs.

Test Plan:
- Reset release, MUTE_CYCLES=4, SETTLE_CYCLES=8:
  - div_rst_n=0 for 1+8 cycles, then div_rst_n=1.
  - mute falls 4 cycles later; busy falls with mute.
  - ack never asserts; osc_sel=0, div1=3, div2=5.
- req=1 with code 3 from IDLE: ack rises exactly 18 cycles after req is sampled.
  - Ordering: mute=1, then div_rst_n low, then osc_sel=1/div1=2/div2=4 on SETTLE entry, then div_rst_n high, then mute=0.
  - Drop req: ack=0 next cycle.
- req with code 6: ack=1 and err=1 one cycle later; mute, osc_sel and div outputs unchanged; busy stays 0.
- req with code equal to cur_code (3 after the previous test): ack in 1 cycle, err=0, mute never asserts.
- Change rate_code 3->5 during SETTLE and drop req during MUTE: final config is code 3; ack high exactly 1 cycle.
- Assert rst_n=0 during SETTLE: outputs return to reset values asynchronously (before the next clk edge); after release, the BOOT sequence reconfigures to code 0.

Source files
------------

// File: rtl/clk_cfg_pkg.sv
// Shared types and the sample-rate table for the audio clock-tree sequencer.
package clk_cfg_pkg;

  // FSM state encoding, kept as plain constants so downstream tools see a fixed code.
  typedef logic [2:0] state_t;
  localparam state_t ST_BOOT   = 3'd0;
  localparam state_t ST_IDLE   = 3'd1;
  localparam state_t ST_MUTE   = 3'd2;
  localparam state_t ST_HOLD   = 3'd3;
  localparam state_t ST_SETTLE = 3'd4;
  localparam state_t ST_UNMUTE = 3'd5;
  localparam state_t ST_ACK    = 3'd6;

  // Rate codes as issued by the FX2LP command decoder.
  localparam logic [2:0] RATE_44K1  = 3'd0;
  localparam logic [2:0] RATE_48K   = 3'd1;
  localparam logic [2:0] RATE_88K2  = 3'd2;
  localparam logic [2:0] RATE_96K   = 3'd3;
  localparam logic [2:0] RATE_176K4 = 3'd4;
  localparam logic [2:0] RATE_192K  = 3'd5;

  // Clock-tree settings for one rate code.
  typedef struct packed {
    logic       valid;
    logic       osc_sel;
    logic [2:0] div1;
    logic [2:0] div2;
  } rate_cfg_t;

  // MCLK is 512fs; odd codes are the 48k family on the 24.576 MHz oscillator.
  function automatic rate_cfg_t rate_lookup(input logic [2:0] code);
    rate_cfg_t cfg;
    cfg.valid   = 1'b1;
    cfg.osc_sel = code[0];
    cfg.div1    = 3'd3;
    cfg.div2    = 3'd5;
    case (code)
      RATE_44K1, RATE_48K: begin
        cfg.div1 = 3'd3;
        cfg.div2 = 3'd5;
      end
      RATE_88K2, RATE_96K: begin
        cfg.div1 = 3'd2;
        cfg.div2 = 3'd4;
      end
      RATE_176K4, RATE_192K: begin
        cfg.div1 = 3'd1;
        cfg.div2 = 3'd3;
      end
      default: cfg.valid = 1'b0;
    endcase
    return cfg;
  endfunction

endpackage

// File: rtl/clk_cfg_timer.sv
// Loadable down-counter used for the mute and settle waits; parks at zero.
module clk_cfg_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  output logic [CNT_W-1:0] value,
  output logic             done
);

  // Load takes priority; otherwise count down until zero and stay there.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
    end else if (load) begin
      value <= load_value;
    end else if (value != '0) begin
      value <= value - 1'b1;
    end
  end

  assign done = (value == '0);

endmodule

// File: rtl/clk_cfg_sequencer.sv
// Glitch-free sample-rate change sequencer: mute, hold divider, switch, settle, release, unmute.
module clk_cfg_sequencer
  import clk_cfg_pkg::*;
#(
  parameter int MUTE_CYCLES   = 256,
  parameter int SETTLE_CYCLES = 1024,
  parameter int CNT_W         = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req,
  input  logic [2:0] rate_code,
  output logic       ack,
  output logic       err,
  output logic       busy,
  output logic       mute,
  output logic       osc_sel,
  output logic       div_rst_n,
  output logic [2:0] div1,
  output logic [2:0] div2
);

  localparam logic [CNT_W-1:0] MUTE_LOAD   = CNT_W'(MUTE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  state_t           state, state_nxt;
  logic [2:0]       cur_code, cur_code_nxt;
  logic [2:0]       req_code, req_code_nxt;
  logic             boot_seq, boot_seq_nxt;
  logic             ack_nxt, err_nxt, busy_nxt, mute_nxt, osc_sel_nxt, div_rst_n_nxt;
  logic [2:0]       div1_nxt, div2_nxt;
  logic [2:0]       lookup_code;
  rate_cfg_t        cfg;
  logic             timer_load;
  logic [CNT_W-1:0] timer_load_value;
  logic             timer_done;
  logic [CNT_W-1:0] unused_wait_count;

  // One table lookup serves all states: incoming code in IDLE, code 0 at boot, latched code otherwise.
  assign lookup_code = (state == ST_IDLE) ? rate_code :
                       (state == ST_BOOT) ? RATE_44K1 : req_code;
  assign cfg = rate_lookup(lookup_code);

  clk_cfg_timer #(.CNT_W(CNT_W)) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (timer_load),
    .load_value(timer_load_value),
    .value     (unused_wait_count),
    .done      (timer_done)
  );

  // Next-state and next-output decode; outputs are registered from these.
  // NOTE: every signal gets a default first so no path leaves one unassigned and infers a latch.
  always_comb begin
    state_nxt        = state;
    cur_code_nxt     = cur_code;
    req_code_nxt     = req_code;
    boot_seq_nxt     = boot_seq;
    ack_nxt          = ack;
    err_nxt          = err;
    busy_nxt         = busy;
    mute_nxt         = mute;
    osc_sel_nxt      = osc_sel;
    div_rst_n_nxt    = div_rst_n;
    div1_nxt         = div1;
    div2_nxt         = div2;
    timer_load       = 1'b0;
    timer_load_value = '0;
    case (state)
      ST_BOOT: begin
        state_nxt        = ST_SETTLE;
        cur_code_nxt     = RATE_44K1;
        osc_sel_nxt      = cfg.osc_sel;
        div1_nxt         = cfg.div1;
        div2_nxt         = cfg.div2;
        timer_load       = 1'b1;
        timer_load_value = SETTLE_LOAD;
      end
      ST_IDLE: begin
        if (req) begin
          req_code_nxt = rate_code;
          if (!cfg.valid) begin
            state_nxt = ST_ACK;
            ack_nxt   = 1'b1;
            err_nxt   = 1'b1;
          end else if (rate_code == cur_code) begin
            state_nxt = ST_ACK;
            ack_nxt   = 1'b1;
            err_nxt   = 1'b0;
          end else begin
            state_nxt        = ST_MUTE;
            mute_nxt         = 1'b1;
            busy_nxt         = 1'b1;
            timer_load       = 1'b1;
            timer_load_value = MUTE_LOAD;
          end
        end
      end
      ST_MUTE: begin
        if (timer_done) begin
          state_nxt     = ST_HOLD;
          div_rst_n_nxt = 1'b0;
        end
      end
      ST_HOLD: begin
        state_nxt        = ST_SETTLE;
        timer_load       = 1'b1;
        timer_load_value = SETTLE_LOAD;
        if (cfg.valid) begin
          cur_code_nxt = req_code;
          osc_sel_nxt  = cfg.osc_sel;
          div1_nxt     = cfg.div1;
          div2_nxt     = cfg.div2;
        end
      end
      ST_SETTLE: begin
        if (timer_done) begin
          state_nxt        = ST_UNMUTE;
          div_rst_n_nxt    = 1'b1;
          timer_load       = 1'b1;
          timer_load_value = MUTE_LOAD;
        end
      end
      ST_UNMUTE: begin
        if (timer_done) begin
          mute_nxt = 1'b0;
          busy_nxt = 1'b0;
          if (boot_seq) begin
            state_nxt    = ST_IDLE;
            boot_seq_nxt = 1'b0;
          end else begin
            state_nxt = ST_ACK;
            ack_nxt   = 1'b1;
            err_nxt   = 1'b0;
          end
        end
      end
      ST_ACK: begin
        if (!req) begin
          state_nxt = ST_IDLE;
          ack_nxt   = 1'b0;
          err_nxt   = 1'b0;
        end
      end
      default: state_nxt = ST_BOOT;
    endcase
  end

  // State and output registers; reset leaves the DAC muted and the divider held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_BOOT;
      cur_code  <= RATE_44K1;
      req_code  <= RATE_44K1;
      boot_seq  <= 1'b1;
      ack       <= 1'b0;
      err       <= 1'b0;
      busy      <= 1'b1;
      mute      <= 1'b1;
      osc_sel   <= 1'b0;
      div_rst_n <= 1'b0;
      div1      <= 3'd3;
      div2      <= 3'd5;
    end else begin
      state     <= state_nxt;
      cur_code  <= cur_code_nxt;
      req_code  <= req_code_nxt;
      boot_seq  <= boot_seq_nxt;
      ack       <= ack_nxt;
      err       <= err_nxt;
      busy      <= busy_nxt;
      mute      <= mute_nxt;
      osc_sel   <= osc_sel_nxt;
      div_rst_n <= div_rst_n_nxt;
      div1      <= div1_nxt;
      div2      <= div2_nxt;
    end
  end

endmodule
